lcd_hd44780_responder: RTL and testbench

- Clock-synchronous model of the HD44780-compatible controller side of the character-LCD bus; the counterpart of our LCD initiator.
- Samples RS/RW/E/DB from the initiator, decodes instructions and data writes, maintains an 80-byte DDRAM, address counter and display-control state, and answers busy-flag and data reads.
- Used as an on-chip loopback target and as the bench responder for LCD driver verification.
- DDRAM is exposed on a read-only side port for the display/scan logic.

---
 rtl/lcd_hd44780_responder_if.sv | 21 ++
 rtl/lcd_hd44780_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_responder_if.sv
// Character-LCD bus between an HD44780-style initiator and its responder.
// Latency: none, this is a wire bundle. Backpressure: the initiator polls the busy flag.
// Ports: lcd_rs/lcd_rw/lcd_e/lcd_db_in from the initiator; lcd_db_out/lcd_db_oe from the responder.
interface lcd_hd44780_responder_if;
  logic       lcd_rs;      // 0 = instruction/status, 1 = data
  logic       lcd_rw;      // 1 = read, 0 = write
  logic       lcd_e;       // enable strobe, synchronous to clk
  logic [7:0] lcd_db_in;   // bus value driven by the initiator
  logic [7:0] lcd_db_out;  // read data returned by the responder
  logic       lcd_db_oe;   // responder is driving the bus

  modport master (
    output lcd_rs, lcd_rw, lcd_e, lcd_db_in,
    input  lcd_db_out, lcd_db_oe
  );

  modport slave (
    input  lcd_rs, lcd_rw, lcd_e, lcd_db_in,
    output lcd_db_out, lcd_db_oe
  );
endinterface

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible controller model: decodes LCD bus cycles, keeps DDRAM, AC and mode state.
// Latency: writes act on the E fall; read data is loaded on the E rise and driven one cycle later.
// Backpressure: busy flag; writes (and data reads) landing while busy are dropped and set overrun.
// Ports: clk/rst; bus (slave side of the LCD bus); busy, ac and mode bits as status outputs;
//        overrun sticky error; disp_addr/disp_data combinational DDRAM scan port.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES      = 20,
  parameter int HOME_CYCLES      = 800,
  parameter int CLEAR_MIN_CYCLES = 800
) (
  input  logic                        clk,
  input  logic                        rst,
  lcd_hd44780_responder_if.slave      bus,
  output logic                        busy,
  output logic [6:0]                  ac,
  output logic                        display_on,
  output logic                        cursor_on,
  output logic                        blink_on,
  output logic                        entry_id,
  output logic                        entry_s,
  output logic                        func_dl,
  output logic                        func_n,
  output logic                        func_f,
  output logic                        overrun,
  input  logic [6:0]                  disp_addr,
  output logic [7:0]                  disp_data
);

  // Clear cannot finish faster than the 80-cycle sweep itself.
  localparam int CLEAR_TOTAL = (CLEAR_MIN_CYCLES > 80) ? CLEAR_MIN_CYCLES : 80;
  localparam int MAX_BH      = (BUSY_CYCLES > HOME_CYCLES) ? BUSY_CYCLES : HOME_CYCLES;
  localparam int MAX_CYC     = (MAX_BH > CLEAR_TOTAL) ? MAX_BH : CLEAR_TOTAL;
  localparam int CW          = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] HOME_LOAD  = CW'(HOME_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_CLEAR
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [6:0]      clr_idx;
  logic            e_q;
  logic [7:0]      ddram [0:79];

  // Returns {mapped, linear index}; mapped=0 means the address has no DDRAM cell.
  function automatic logic [7:0] lin_map(input logic [6:0] a, input logic two_line);
    if (two_line) begin
      if (a <= 7'h27)                      return {1'b1, a};
      else if (a >= 7'h40 && a <= 7'h67)   return {1'b1, a - 7'd24};
      else                                 return 8'h00;
    end else begin
      if (a <= 7'h4F)                      return {1'b1, a};
      else                                 return 8'h00;
    end
  endfunction

  // Next AC value; line ends wrap, out-of-map values just step modulo 128.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc,
                                         input logic two_line);
    if (two_line) begin
      if (inc) begin
        if (a == 7'h27)      return 7'h40;
        else if (a == 7'h67) return 7'h00;
        else                 return a + 7'd1;
      end else begin
        if (a == 7'h00)      return 7'h67;
        else if (a == 7'h40) return 7'h27;
        else                 return a - 7'd1;
      end
    end else begin
      if (inc) return (a == 7'h4F) ? 7'h00 : a + 7'd1;
      else     return (a == 7'h00) ? 7'h4F : a - 7'd1;
    end
  endfunction

  logic       rise, fall, wr_fall, rd_fall, idle;
  logic [7:0] ac_map;
  logic       ac_mapped;
  logic [6:0] ac_idx;
  logic [6:0] ac_next;
  logic [7:0] rd_ddram;

  assign rise      = bus.lcd_e & ~e_q;
  assign fall      = ~bus.lcd_e & e_q;
  assign wr_fall   = fall & ~bus.lcd_rw;
  assign rd_fall   = fall & bus.lcd_rw & bus.lcd_rs;
  assign idle      = (state == ST_IDLE);
  assign ac_map    = lin_map(ac, func_n);
  assign ac_mapped = ac_map[7];
  assign ac_idx    = ac_map[6:0];
  assign ac_next   = ac_step(ac, entry_id, func_n);
  assign rd_ddram  = ac_mapped ? ddram[ac_idx] : 8'h20;

  // Bus is driven only once the responder has seen the rise.
  assign bus.lcd_db_oe = bus.lcd_e & bus.lcd_rw & e_q;

  assign disp_data = (disp_addr < 7'd80) ? ddram[disp_addr] : 8'h20;

  // Accepted-access decode: which accesses start a busy period and how long.
  logic          acc;
  logic          to_clear;
  logic [CW-1:0] acc_load;

  always_comb begin
    acc      = 1'b0;
    to_clear = 1'b0;
    acc_load = BUSY_LOAD;
    if (idle && fall) begin
      if (!bus.lcd_rw) begin
        if (bus.lcd_rs) begin
          acc = 1'b1;
        end else if (bus.lcd_db_in == 8'h01) begin
          to_clear = 1'b1;
        end else if (bus.lcd_db_in[7:1] == 7'h01) begin
          acc      = 1'b1;
          acc_load = HOME_LOAD;
        end else if (bus.lcd_db_in != 8'h00) begin
          acc = 1'b1;
        end
      end else if (bus.lcd_rs) begin
        acc = 1'b1;
      end
    end
  end

  // Single DDRAM write port shared by the clear sweep and data writes;
  // the two never overlap because data writes need the IDLE state.
  logic       mem_we;
  logic [6:0] mem_idx;
  logic [7:0] mem_dat;

  always_comb begin
    mem_we  = 1'b0;
    mem_idx = clr_idx;
    mem_dat = 8'h20;
    if (state == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (idle && wr_fall && bus.lcd_rs && ac_mapped) begin
      mem_we  = 1'b1;
      mem_idx = ac_idx;
      mem_dat = bus.lcd_db_in;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) ddram[mem_idx] <= mem_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_CLEAR;
      busy           <= 1'b1;
      cnt            <= CLEAR_LOAD;
      clr_idx        <= 7'd0;
      e_q            <= 1'b0;
      ac             <= 7'd0;
      entry_id       <= 1'b1;
      entry_s        <= 1'b0;
      display_on     <= 1'b0;
      cursor_on      <= 1'b0;
      blink_on       <= 1'b0;
      func_dl        <= 1'b1;
      func_n         <= 1'b0;
      func_f         <= 1'b0;
      overrun        <= 1'b0;
      bus.lcd_db_out <= 8'h00;
    end else begin
      e_q <= bus.lcd_e;

      if (rise && bus.lcd_rw) begin
        bus.lcd_db_out <= bus.lcd_rs ? rd_ddram : {busy, ac};
      end

      // Busy-flag reads are harmless; every other access landing while busy is lost.
      if (busy && fall && (bus.lcd_rs || !bus.lcd_rw)) begin
        overrun <= 1'b1;
      end

      // Architectural side effects of accepted accesses.
      if (idle && wr_fall && !bus.lcd_rs) begin
        casez (bus.lcd_db_in)
          8'b1???????: ac <= bus.lcd_db_in[6:0];
          8'b01??????: ;
          8'b001?????: begin
            func_dl <= bus.lcd_db_in[4];
            func_n  <= bus.lcd_db_in[3];
            func_f  <= bus.lcd_db_in[2];
          end
          8'b0001????: ;
          8'b00001???: begin
            display_on <= bus.lcd_db_in[2];
            cursor_on  <= bus.lcd_db_in[1];
            blink_on   <= bus.lcd_db_in[0];
          end
          8'b000001??: begin
            entry_id <= bus.lcd_db_in[1];
            entry_s  <= bus.lcd_db_in[0];
          end
          8'b0000001?: ac <= 7'd0;
          8'b00000001: begin
            ac       <= 7'd0;
            entry_id <= 1'b1;
          end
          default: ;
        endcase
      end else if (idle && fall && bus.lcd_rs) begin
        ac <= ac_next;
      end

      case (state)
        ST_IDLE: begin
          if (to_clear) begin
            state   <= ST_CLEAR;
            busy    <= 1'b1;
            cnt     <= CLEAR_LOAD;
            clr_idx <= 7'd0;
          end else if (acc) begin
            state <= ST_BUSY;
            busy  <= 1'b1;
            cnt   <= acc_load;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_idx == 7'd79) begin
            clr_idx <= 7'd0;
            // Sweep done; stay busy for whatever remains of the clear time.
            if (cnt == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_BUSY;
              cnt   <= cnt - 1'b1;
            end
          end else begin
            clr_idx <= clr_idx + 7'd1;
            cnt     <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder: drives LCD bus cycles as an initiator would.
// Read data expectations are queued when a read is issued and retired when the responder drives the bus.
// Mode/AC/DDRAM state is compared against constants derived from the instruction sequence.
module tb_lcd_hd44780_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [6:0] ac;
  logic       display_on, cursor_on, blink_on;
  logic       entry_id, entry_s;
  logic       func_dl, func_n, func_f;
  logic       overrun;
  logic [6:0] disp_addr = 7'd0;
  logic [7:0] disp_data;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] rd_exp_q [$];

  lcd_hd44780_responder_if bus ();

  lcd_hd44780_responder dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy       (busy),
    .ac         (ac),
    .display_on (display_on),
    .cursor_on  (cursor_on),
    .blink_on   (blink_on),
    .entry_id   (entry_id),
    .entry_s    (entry_s),
    .func_dl    (func_dl),
    .func_n     (func_n),
    .func_f     (func_f),
    .overrun    (overrun),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lcd_write(input logic rs, input logic [7:0] d);
    bus.lcd_rs    = rs;
    bus.lcd_rw    = 1'b0;
    bus.lcd_db_in = d;
    bus.lcd_e     = 1'b1;
    tick();
    bus.lcd_e = 1'b0;
    tick();
  endtask

  task automatic lcd_read(input string tag, input logic rs, input logic [7:0] exp);
    rd_exp_q.push_back(exp);
    bus.lcd_rs = rs;
    bus.lcd_rw = 1'b1;
    bus.lcd_e  = 1'b1;
    #1;
    check_eq({tag, "_oe_rise"}, bus.lcd_db_oe, 1'b0);
    tick();
    check_eq({tag, "_oe_on"}, bus.lcd_db_oe, 1'b1);
    check_eq(tag, bus.lcd_db_out, rd_exp_q.pop_front());
    tick();
    check_eq({tag, "_oe_hold"}, bus.lcd_db_oe, 1'b1);
    bus.lcd_e = 1'b0;
    #1;
    check_eq({tag, "_oe_off"}, bus.lcd_db_oe, 1'b0);
    tick();
    bus.lcd_rw = 1'b0;
  endtask

  // Cycles spent with busy high, bounded so a stuck flag still ends the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic peek(input string tag, input int idx, input logic [7:0] exp);
    disp_addr = 7'(idx);
    #1;
    check_eq(tag, disp_data, exp);
  endtask

  task automatic check_all_blank(input string tag);
    int bad = 0;
    for (int i = 0; i < 80; i++) begin
      disp_addr = 7'(i);
      #1;
      if (disp_data !== 8'h20) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.lcd_rs    = 1'b0;
    bus.lcd_rw    = 1'b0;
    bus.lcd_e     = 1'b0;
    bus.lcd_db_in = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and the power-on clear sweep.
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_ac", ac, 7'h00);
    check_eq("rst_entry_id", entry_id, 1'b1);
    check_eq("rst_func_dl", func_dl, 1'b1);
    check_eq("rst_func_n", func_n, 1'b0);
    check_eq("rst_display_on", display_on, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_db_out", bus.lcd_db_out, 8'h00);
    count_busy(n);
    check_eq("rst_busy_cycles", n, 800);
    check_all_blank("rst_blank");

    // Initialisation sequence and first three characters.
    lcd_write(1'b0, 8'h38);
    count_busy(n);
    check_eq("instr_busy_cycles", n, 20);
    lcd_write(1'b0, 8'h0E);  count_busy(n);
    lcd_write(1'b0, 8'h06);  count_busy(n);
    lcd_write(1'b1, 8'h48);  count_busy(n);
    check_eq("data_busy_cycles", n, 20);
    lcd_write(1'b1, 8'h45);  count_busy(n);
    lcd_write(1'b1, 8'h4C);  count_busy(n);
    check_eq("init_func_n", func_n, 1'b1);
    check_eq("init_display_on", display_on, 1'b1);
    check_eq("init_cursor_on", cursor_on, 1'b1);
    check_eq("init_blink_on", blink_on, 1'b0);
    check_eq("init_entry_id", entry_id, 1'b1);
    peek("ddram0", 0, 8'h48);
    peek("ddram1", 1, 8'h45);
    peek("ddram2", 2, 8'h4C);
    check_eq("init_ac", ac, 7'h03);
    lcd_read("bf_idle", 1'b0, 8'h03);
    count_busy(n);
    check_eq("bf_read_no_busy", n, 0);

    // Line 1 end wraps onto line 2.
    lcd_write(1'b0, 8'hA7);  count_busy(n);
    check_eq("set_ac_27", ac, 7'h27);
    lcd_write(1'b1, 8'h41);  count_busy(n);
    peek("ddram39", 39, 8'h41);
    check_eq("wrap_ac_40", ac, 7'h40);
    lcd_write(1'b1, 8'h42);  count_busy(n);
    peek("ddram40", 40, 8'h42);
    check_eq("ac_41", ac, 7'h41);

    // Decrement from 0 wraps to the end of line 2.
    lcd_write(1'b0, 8'h04);  count_busy(n);
    check_eq("dec_entry_id", entry_id, 1'b0);
    lcd_write(1'b0, 8'h80);  count_busy(n);
    lcd_write(1'b1, 8'h5A);  count_busy(n);
    peek("ddram0_dec", 0, 8'h5A);
    check_eq("dec_wrap_ac_67", ac, 7'h67);

    // Access while busy: busy read is served, write is dropped and flagged.
    check_eq("overrun_clear", overrun, 1'b0);
    lcd_write(1'b0, 8'h06);
    tick();
    lcd_read("bf_busy", 1'b0, 8'hE7);
    lcd_write(1'b0, 8'h0C);
    check_eq("overrun_set", overrun, 1'b1);
    count_busy(n);
    check_eq("dropped_cursor_on", cursor_on, 1'b1);
    check_eq("restored_entry_id", entry_id, 1'b1);

    // Data read returns DDRAM and steps AC on the fall.
    lcd_write(1'b0, 8'h81);  count_busy(n);
    check_eq("set_ac_01", ac, 7'h01);
    lcd_read("data_rd", 1'b1, 8'h45);
    check_eq("rd_ac_step", ac, 7'h02);
    count_busy(n);
    check_eq("rd_busy_cycles", n, 20);

    // Clear Display after switching to decrement.
    lcd_write(1'b0, 8'h04);  count_busy(n);
    check_eq("pre_clear_entry_id", entry_id, 1'b0);
    lcd_write(1'b0, 8'h01);
    count_busy(n);
    check_eq("clear_busy_cycles", n, 800);
    check_all_blank("clear_blank");
    check_eq("clear_ac", ac, 7'h00);
    check_eq("clear_entry_id", entry_id, 1'b1);
    check_eq("overrun_sticky", overrun, 1'b1);

    // Return Home.
    lcd_write(1'b0, 8'h85);  count_busy(n);
    check_eq("set_ac_05", ac, 7'h05);
    lcd_write(1'b0, 8'h02);
    count_busy(n);
    check_eq("home_busy_cycles", n, 800);
    check_eq("home_ac", ac, 7'h00);

    check_eq("sb_drain", rd_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
